// File: rtl/persiana_planta.sv
// persiana_planta: plant model of a motorised blind.
// The blind is driven by raise/lower commands and reports its position, the
// three position sensors, motion/limit status and a sticky conflicting-command
// fault.
module persiana_planta #(
    parameter int unsigned TICK_DIV = 16,
    parameter int unsigned POS_MAX  = 200,
    parameter int unsigned POS_MID  = 100,
    parameter int unsigned SENS_WIN = 2,
    parameter int unsigned POS_INI  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       subir,
    input  logic       bajar,
    output logic       Sinf,
    output logic       Smed,
    output logic       Ssup,
    output logic [7:0] posicion,
    output logic       moviendo,
    output logic       tope,
    output logic       falla
);

    localparam int unsigned PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SMED_HI = POS_MID + SENS_WIN;

    // Registered state
    logic [PW-1:0] presc_q;
    logic [7:0]    pos_q;
    logic          falla_q;
    logic          solape_q;
    logic [1:0]    cmd_q;

    // Next-state values
    logic [PW-1:0] presc_d;
    logic [7:0]    pos_d;
    logic          falla_d;
    logic          solape_d;
    logic [1:0]    cmd_d;

    // Combinational helpers
    logic          cmd_val_c;
    logic          cmd_cambio_c;
    logic          tope_c;
    logic          mov_c;
    logic [PW-1:0] presc_eff_c;
    logic          paso_c;

    // State register: position, prescaler, fault, overlap detector, last command
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q  <= '0;
            pos_q    <= 8'(POS_INI);
            falla_q  <= 1'b0;
            solape_q <= 1'b0;
            cmd_q    <= 2'b00;
        end else begin
            presc_q  <= presc_d;
            pos_q    <= pos_d;
            falla_q  <= falla_d;
            solape_q <= solape_d;
            cmd_q    <= cmd_d;
        end
    end

    // Next state: a command change restarts the step count from zero
    always_comb begin
        presc_d      = '0;
        pos_d        = pos_q;
        falla_d      = falla_q;
        solape_d     = subir & bajar;
        cmd_d        = {subir, bajar};
        cmd_val_c    = (subir ^ bajar) & ~falla_q;
        tope_c       = ((subir & ~bajar & (pos_q == 8'(POS_MAX))) |
                        (bajar & ~subir & (pos_q == 8'd0))) & ~falla_q;
        mov_c        = cmd_val_c & ~tope_c;
        cmd_cambio_c = ({subir, bajar} != cmd_q);
        presc_eff_c  = cmd_cambio_c ? '0 : presc_q;
        paso_c       = mov_c & (presc_eff_c == PW'(TICK_DIV - 1));

        if (subir & bajar & solape_q) begin
            falla_d = 1'b1;
        end

        if (mov_c) begin
            presc_d = paso_c ? '0 : presc_eff_c + PW'(1);
        end

        if (paso_c) begin
            if (subir) begin
                pos_d = (pos_q < 8'(POS_MAX)) ? pos_q + 8'd1 : pos_q;
            end else begin
                pos_d = (pos_q != 8'd0) ? pos_q - 8'd1 : pos_q;
            end
        end
    end

    // Outputs: sensors and status decoded straight from the position register
    always_comb begin
        posicion = pos_q;
        falla    = falla_q;
        Sinf     = (pos_q == 8'd0);
        Ssup     = (pos_q == 8'(POS_MAX));
        Smed     = ((32'(pos_q) + SENS_WIN) >= POS_MID) && (32'(pos_q) <= SMED_HI);
        tope     = tope_c;
        moviendo = mov_c;
    end

endmodule

// File: doc/persiana_planta.md
PERSIANA_PLANTA -- requirements
Module: persiana_planta

Interface
REQ-001 The block SHALL provide parameter TICK_DIV, default 16: clock cycles per one position step.
REQ-002 The block SHALL provide parameter POS_MAX, default 200: position value for fully open, range 2..255.
REQ-003 The block SHALL provide parameter POS_MID, default 100: position value for half open.
REQ-004 The block SHALL provide parameter SENS_WIN, default 2: half-width of the Smed detection window.
REQ-005 The block SHALL provide parameter POS_INI, default 0: position loaded on reset.
REQ-006 clk  input  1  single system clock; all state changes on the rising edge.
REQ-007 reset_n  input  1  asynchronous active-low reset.
REQ-008 subir  input  1  motor raise command from the blind controller.
REQ-009 bajar  input  1  motor lower command from the blind controller.
REQ-010 Sinf  output  1  lower limit sensor, fully closed.
REQ-011 Smed  output  1  middle sensor.
REQ-012 Ssup  output  1  upper limit sensor, fully open.
REQ-013 posicion  output  8  current blind position, 0 = closed.
REQ-014 moviendo  output  1  motor is effectively moving.
REQ-015 tope  output  1  motor is commanded against a limit.
REQ-016 falla  output  1  sticky fault: conflicting commands.

Function
REQ-017 The block SHALL treat the command as valid only when exactly one of subir/bajar is 1 and falla is 0.
REQ-018 The block SHALL run a prescaler counting 0..TICK_DIV-1 while the command is valid and the blind is not at the commanded limit; otherwise the prescaler SHALL hold 0.
REQ-019 The block SHALL clear the prescaler to 0 on any change of command, including direction reversal and a return to idle.
REQ-020 On the edge where the prescaler equals TICK_DIV-1, the block SHALL wrap the prescaler to 0 and step posicion +1 (subir) or -1 (bajar).
REQ-021 With a valid command held continuously from a non-limit position, the first step SHALL occur on the TICK_DIV-th rising edge; later steps SHALL follow every TICK_DIV edges.
REQ-022 posicion SHALL saturate: never above POS_MAX with subir, never below 0 with bajar, no wrap-around.
REQ-023 Sinf SHALL be combinational from the position register: 1 iff posicion == 0.
REQ-024 Ssup SHALL be combinational from the position register: 1 iff posicion == POS_MAX.
REQ-025 Smed SHALL be combinational from the position register: 1 iff POS_MID-SENS_WIN <= posicion <= POS_MID+SENS_WIN, using unsigned arithmetic clamped at 0 and POS_MAX.
REQ-026 tope SHALL be combinational: (subir & ~bajar & posicion==POS_MAX) | (bajar & ~subir & posicion==0), gated off by falla.
REQ-027 moviendo SHALL be combinational: valid command & ~tope.
REQ-028 When subir=bajar=1 on two consecutive rising edges, the block SHALL set falla on the second edge.
REQ-029 falla SHALL stay set until reset.
REQ-030 While falla is set, posicion SHALL freeze and the prescaler SHALL hold 0.
REQ-031 A single-cycle overlap of subir and bajar SHALL NOT set falla; that cycle SHALL count as a command change per REQ-019.

Reset
REQ-032 reset_n low SHALL immediately force posicion=POS_INI, prescaler=0, falla=0, and the overlap detector to 0.
REQ-033 All outputs SHALL reflect REQ-023..REQ-027 for POS_INI while reset is held; with defaults, Sinf=1 and all other outputs 0.
REQ-034 Reset asserted mid-step SHALL discard the partial prescaler count.
REQ-035 Deassertion SHALL take effect at the next rising edge.

Verification (defaults: TICK_DIV=16, POS_MAX=200, POS_MID=100, SENS_WIN=2, POS_INI=0)
REQ-036 Reset pulse, inputs 0 -> posicion=0, Sinf=1, Smed=Ssup=moviendo=tope=falla=0.
REQ-037 subir=1 held 16 edges -> posicion=1 after the 16th edge, Sinf=0, moviendo=1; at 15 edges posicion still 0.
REQ-038 subir held 3200 edges -> posicion=200, Ssup=1, tope=1, moviendo=0; further 100 edges -> posicion stays 200.
REQ-039 Sweep up from 0 -> Smed=1 exactly for posicion 98..102, and 0 at 97 and 103.
REQ-040 subir for 10 edges then bajar from posicion=5 -> no step at the 6th bajar edge; posicion=4 after the 16th bajar edge.
REQ-041 subir=bajar=1 for 1 edge -> falla=0; for 2 edges -> falla=1, posicion frozen under a later valid subir; reset_n pulse -> falla=0, posicion=0.
